// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit carry look-ahead nibble per clock, carry held between
// nibbles, start/busy/done handshake. WIDTH must be a multiple of 4 and at least 4.
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C
);

  localparam int unsigned N    = WIDTH / 4;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              c_q, c_d;

  logic [3:0]        a_nib, b_nib, p, g, s_nib;
  logic [4:0]        cy;
  logic [WIDTH-1:0]  sum_new;
  logic              last;

  // Nibble slice, CLA nibble adder, and merge of the new sum nibble into the working sum.
  always_comb begin
    a_nib   = '0;
    b_nib   = '0;
    sum_new = sum_q;
    for (int k = 0; k < N; k++) begin
      if (idx_q == IdxW'(k)) begin
        a_nib = a_q[4*k +: 4];
        b_nib = b_q[4*k +: 4];
      end
    end
    p     = a_nib ^ b_nib;
    g     = a_nib & b_nib;
    cy[0] = carry_q;
    cy[1] = g[0] | (p[0] & cy[0]);
    cy[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cy[0]);
    cy[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cy[0]);
    cy[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & cy[0]);
    s_nib = p ^ cy[3:0];
    for (int k = 0; k < N; k++) begin
      if (idx_q == IdxW'(k)) sum_new[4*k +: 4] = s_nib;
    end
    last = (idx_q == IdxW'(N - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    s_d     = s_q;
    c_d     = c_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          sum_d   = '0;
          carry_d = c;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d   = sum_new;
        carry_d = cy[4];
        idx_d   = idx_q + 1'b1;
        if (last) begin
          s_d     = sum_new;
          c_d     = cy[4];
          idx_d   = '0;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      c_q     <= c_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign S    = s_q;
  assign C    = c_q;

endmodule
